shift_add_mult_ctrl: RTL and testbench
======================================

// Module: shift_add_mult_ctrl
// PURPOSE
//  Sequencer for the classic multiplier: computes an unsigned WIDTH x WIDTH product
//  by time-sharing one (WIDTH+1)-bit ripple adder over WIDTH add/shift iterations.
//  It owns the operand handshake, iteration counter, partial-product register and
//  result hold. It sits between the operand source and the product consumer.
// PARAMETERS
//  WIDTH   8   operand width in bits; product width is 2*WIDTH; legal range 2..32
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operands a/b valid
//  in_ready   out  1        block can accept operands (high only in IDLE)
//  a          in   WIDTH    multiplicand, unsigned
//  b          in   WIDTH    multiplier, unsigned
//  out_valid  out  1        product valid (high only in DONE)
//  out_ready  in   1        consumer takes product
//  product    out  2*WIDTH  a*b, held stable while out_valid
//  busy       out  1        high in RUN or DONE
// BEHAVIOUR
//  Reset: on rst=1 at the clock edge -> state IDLE, count=0, P=0, mcand=0.
//   Outputs after reset: in_ready=1, out_valid=0, busy=0, product=0.
//   rst mid-RUN or mid-DONE aborts the operation; no output is produced.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. If in_valid: mcand<=a, P<={(WIDTH+1)'0, b}, count<=0, go to RUN.
//   RUN: executes one iteration per cycle and increments count. After the iteration
//    with count==WIDTH-1, go to DONE.
//   DONE: out_valid=1 and product=P[2*WIDTH-1:0]. If out_ready, go to IDLE.
//    While out_ready=0, stay in DONE with product unchanged.
//  Iteration, with P = {hi[WIDTH:0], lo[WIDTH-1:0]}:
//   sum = lo[0] ? hi + {1'b0,mcand} : hi       ((WIDTH+1)-bit, no overflow past bit WIDTH)
//   P  <= {sum, lo} >> 1                       (logical shift; the carry enters the top)
//  Latency: acceptance edge = cycle 0; out_valid rises at cycle WIDTH+1.
//   Minimum throughput is one product per WIDTH+2 cycles.
//  in_valid/a/b are ignored outside IDLE. out_ready is ignored outside DONE.
//   in_ready and out_valid are never high together.
//  Boundary results: a=0 or b=0 -> product 0. a=b=2^WIDTH-1 -> (2^WIDTH-1)^2, with no
//   truncation. in_valid held high continuously -> a new operand pair is accepted in
//   the first IDLE cycle after each DONE handshake.
// CONFIGURATION
//  ZERO_SKIP_EN defined: in IDLE, if in_valid and (a==0 or b==0), go straight to DONE
//   with P=0 and skip RUN. out_valid rises at cycle 1.
//  ZERO_SKIP_EN undefined: zero operands take the full WIDTH-iteration path.
//   The result is identical; only latency differs.
// STRUCTURE
//  Package mult_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default WIDTH.
//  Sub-module add_shift_step (combinational): inputs hi, lo, mcand; output next P.
//   Contains the (WIDTH+1)-bit adder built from the existing half/full adder cells.
//  The controller holds the FSM, counter, mcand and P registers.
// TESTING
//  1. Reset, then WIDTH=8, a=13, b=11 -> product=143, out_valid at cycle 9,
//     in_ready=0 during cycles 1..9.
//  2. a=255, b=255 -> product=65025 (0xFE01); checks carry into P[2*WIDTH-1].
//  3. a=0, b=200 -> product=0. out_valid at cycle 1 with ZERO_SKIP_EN defined,
//     at cycle 9 without it.
//  4. Hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0.
//     Then out_ready=1 -> IDLE on the next cycle.
//  5. Assert rst at cycle 4 of a RUN -> next cycle IDLE, out_valid=0, product=0.
//     A new pair a=7, b=6 then yields 42.
//  6. Back-to-back pairs with in_valid held high and out_ready=1, plus a random
//     sweep of 1000 pairs -> each product matches a*b. Spacing is WIDTH+2 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift/add multiplier.
// Contents: FSM state encoding, default operand width, and the half/full
// adder cells used to build the iteration adder.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Half adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/add_shift_step.sv
// One add/shift iteration of the multiplier (purely combinational).
// Ports:
//   hi_i     [WIDTH:0]     upper part of the partial-product register
//   lo_i     [WIDTH-1:0]   lower part (remaining multiplier bits)
//   mcand_i  [WIDTH-1:0]   multiplicand
//   p_o      [2*WIDTH:0]   partial-product register after this iteration
module add_shift_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]     hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH:0]   p_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             carry;

  // Ripple adder: hi + (lo[0] ? mcand : 0). The addend's top bit is zero,
  // so bit WIDTH only absorbs the carry; the result never overflows.
  always_comb begin
    addend = lo_i[0] ? mcand_i : '0;
    sum    = '0;
    carry  = 1'b0;
    {carry, sum[0]} = half_add(hi_i[0], addend[0]);
    for (int unsigned i = 1; i < WIDTH; i++) begin
      {carry, sum[i]} = full_add(hi_i[i], addend[i], carry);
    end
    sum[WIDTH] = hi_i[WIDTH] ^ carry;
  end

  // Logical right shift of {sum, lo}; the consumed multiplier bit drops out.
  assign p_o = {1'b0, sum, lo_i[WIDTH-1:1]};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an unsigned WIDTH x WIDTH shift/add multiplier.
// Owns the operand handshake, iteration counter, partial-product register
// and result hold. One iteration per cycle through add_shift_step.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//   a, b                 multiplicand / multiplier
//   out_valid/out_ready  product handshake (out_valid high only in DONE)
//   product              a*b, held while out_valid
//   busy                 high in RUN or DONE
// Build option: define ZERO_SKIP_EN to bypass RUN when an operand is zero.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH + 1;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [PW-1:0]      p_q;
  logic [PW-1:0]      p_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] product_q;

  add_shift_step #(.WIDTH(WIDTH)) u_step (
    .hi_i    (p_q[PW-1:WIDTH]),
    .lo_i    (p_q[WIDTH-1:0]),
    .mcand_i (mcand_q),
    .p_o     (p_d)
  );

  // FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mcand_q     <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= a;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
              p_q         <= '0;
              product_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              p_q     <= {{(WIDTH + 1){1'b0}}, b};
              state_q <= RUN;
            end
`else
            p_q     <= {{(WIDTH + 1){1'b0}}, b};
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          p_q     <= p_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            product_q   <= p_d[2*WIDTH-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_tests;
  int n_fail;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef ZERO_SKIP_EN
    if ((x == '0) || (y == '0)) return 1;
`endif
    return W + 1;
  endfunction

  // Present a pair for one edge (the acceptance edge = cycle 0).
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
  endtask

  // Wait (bounded) for out_valid; check latency, product and side outputs.
  task automatic wait_done(input string tag, input int lat, input logic [2*W-1:0] exp_p);
    int cyc;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  // Handshake edge with out_ready=1; block must be back in IDLE afterwards.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);

    // 1: 13 * 11
    out_ready = 1'b1;
    start_op(8'd13, 8'd11);
    in_valid = 1'b0;
    wait_done("t1", 9, 16'd143);
    handshake("t1");

    // 2: full-scale operands, carry into the top product bit
    start_op(8'd255, 8'd255);
    in_valid = 1'b0;
    wait_done("t2", 9, 16'hFE01);
    handshake("t2");

    // 3: zero operands
    start_op(8'd0, 8'd200);
    in_valid = 1'b0;
    wait_done("t3a", exp_lat(8'd0, 8'd200), 16'd0);
    handshake("t3a");
    start_op(8'd77, 8'd0);
    in_valid = 1'b0;
    wait_done("t3b", exp_lat(8'd77, 8'd0), 16'd0);
    handshake("t3b");

    // 4: consumer stalls for 5 cycles in DONE
    out_ready = 1'b0;
    start_op(8'd100, 8'd3);
    in_valid = 1'b0;
    wait_done("t4", 9, 16'd300);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_product", 32'(product), 32'd300);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
    end
    handshake("t4");

    // 5: reset in the middle of RUN aborts, then a fresh pair
    start_op(8'd200, 8'd150);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_product", 32'(product), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    start_op(8'd7, 8'd6);
    in_valid = 1'b0;
    wait_done("t5", 9, 16'd42);
    handshake("t5");

    // 6a: back-to-back with in_valid held high; operands changed during RUN
    // must be ignored.
    in_valid = 1'b1;
    a = 8'd3;
    b = 8'd5;
    for (int i = 0; i < 4; i++) begin
      ra = 8'(37 * i + 19);
      rb = 8'(91 - 13 * i);
      a = ra;
      b = rb;
      tick();
      a = ~ra;
      b = ~rb;
      wait_done("t6a", 9, 16'(ra) * 16'(rb));
      handshake("t6a");
    end

    // 6b: random sweep, still with in_valid held high
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 0) ra = 8'd0;
      if (i == 1) rb = 8'd0;
      a = ra;
      b = rb;
      tick();
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      wait_done("t6b", exp_lat(ra, rb), 16'(ra) * 16'(rb));
      handshake("t6b");
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
